// File: rtl/mc_alu_if.sv
// Issue/writeback handshake bundle for mc_alu: one operation in, one result out.
interface mc_alu_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             carry;
    logic             dz;

    modport master (
        output in_valid, ctl, a, b, out_ready,
        input  in_ready, out_valid, out, zero, carry, dz
    );

    modport slave (
        input  in_valid, ctl, a, b, out_ready,
        output in_ready, out_valid, out, zero, carry, dz
    );
endinterface

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/add/shift, WIDTH-cycle shift-add MUL and
// restoring DIV/REM, result and flags held until the consumer takes them.
module mc_alu #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input logic     clk,
    input logic     rst,
    mc_alu_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_DIV = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_XOR = 4'd10;
    localparam logic [3:0] OP_REM = 4'd11;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nx;
    logic [3:0]         op_in, op_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   out_q;
    logic               carry_q, dz_q;
    logic               accept, iter_op;

    logic [WIDTH-1:0]   res_1c;
    logic               carry_1c, dz_1c;
    logic [WIDTH:0]     sum_w, diff_w;

    logic [WIDTH:0]     mul_sum, div_sh, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_nx, div_nx, iter_nx;
    logic [WIDTH-1:0]   iter_res;

    // Undefined opcodes behave as ADD.
    always_comb begin
        op_in = bus.ctl;
        if (bus.ctl == 4'd0 || bus.ctl > OP_REM) op_in = OP_ADD;
    end

    assign accept  = bus.in_valid && bus.in_ready;
    assign iter_op = (op_in == OP_MUL) ||
                     ((op_in == OP_DIV || op_in == OP_REM) && bus.b != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept)                            state_nx = iter_op ? BUSY : DONE;
                else if (state == DONE && bus.out_ready) state_nx = IDLE;
            end
            BUSY:    if (cnt == CNT_W'(1)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // A held result may be replaced in the same cycle it is consumed.
    always_comb begin
        bus.out_valid = (state == DONE);
        bus.in_ready  = (state != BUSY) && (state != DONE || bus.out_ready);
        bus.out       = out_q;
        bus.zero      = (out_q == '0);
        bus.carry     = carry_q;
        bus.dz        = dz_q;
    end

    always_comb begin
        res_1c   = '0;
        carry_1c = 1'b0;
        dz_1c    = 1'b0;
        sum_w    = {1'b0, bus.a} + {1'b0, bus.b};
        diff_w   = {1'b0, bus.a} - {1'b0, bus.b};
        case (op_in)
            OP_SUB: begin
                res_1c   = diff_w[WIDTH-1:0];
                carry_1c = diff_w[WIDTH];
            end
            OP_SHL: res_1c = (bus.b >= W_VAL) ? '0 : (bus.a << bus.b);
            OP_SHR: res_1c = (bus.b >= W_VAL) ? '0 : (bus.a >> bus.b);
            OP_DIV: begin
                res_1c = '1;
                dz_1c  = 1'b1;
            end
            OP_REM: begin
                res_1c = bus.a;
                dz_1c  = 1'b1;
            end
            OP_NOT: res_1c = ~bus.a;
            OP_AND: res_1c = bus.a & bus.b;
            OP_OR:  res_1c = bus.a | bus.b;
            OP_XOR: res_1c = bus.a ^ bus.b;
            default: begin
                res_1c   = sum_w[WIDTH-1:0];
                carry_1c = sum_w[WIDTH];
            end
        endcase
    end

    // acc holds {high, low}: product halves for MUL, {remainder, dividend/quotient} for DIV/REM.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
        mul_nx   = {mul_sum, acc[WIDTH-1:1]};
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_sub  = div_sh - {1'b0, b_q};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_nx   = {(div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        iter_nx  = (op_q == OP_MUL) ? mul_nx : div_nx;
        iter_res = (op_q == OP_MUL) ? mul_nx[WIDTH-1:0] :
                   (op_q == OP_REM) ? div_nx[2*WIDTH-1:WIDTH] : div_nx[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 4'd0;
            b_q     <= '0;
            acc     <= '0;
            cnt     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (accept) begin
            op_q <= op_in;
            b_q  <= bus.b;
            acc  <= {{WIDTH{1'b0}}, bus.a};
            if (iter_op) begin
                cnt <= CNT_W'(WIDTH);
            end else begin
                out_q   <= res_1c;
                carry_q <= carry_1c;
                dz_q    <= dz_1c;
            end
        end else if (state == BUSY) begin
            acc <= iter_nx;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                out_q   <= iter_res;
                carry_q <= (op_q == OP_MUL) && (|mul_nx[2*WIDTH-1:WIDTH]);
                dz_q    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mc_alu.sv
// Directed self-checking bench for mc_alu at WIDTH=64 and WIDTH=8.
module tb_mc_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mc_alu_if #(.WIDTH(64)) i64 ();
    mc_alu_if #(.WIDTH(8))  i8 ();

    mc_alu #(.WIDTH(64)) u64 (.clk(clk), .rst(rst), .bus(i64));
    mc_alu #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] lat;
        logic [7:0] res;
        logic       c;
        logic       dz;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [0:NV-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go64(input logic [3:0] op, input logic [63:0] aa, input logic [63:0] bb);
        i64.ctl = op; i64.a = aa; i64.b = bb; i64.in_valid = 1'b1;
        step();
        i64.in_valid = 1'b0;
    endtask

    // Issue one 8-bit vector, measure latency and compare the held result.
    task automatic run8(input vec_t v, input int idx);
        int n;
        int lat;
        i8.ctl = v.op; i8.a = v.a; i8.b = v.b; i8.in_valid = 1'b1;
        n = 0;
        while (!i8.in_ready && n < 50) begin
            step();
            n++;
        end
        check($sformatf("v%0d_issue", idx), 64'(i8.in_ready), 64'd1);
        step();
        i8.in_valid = 1'b0;
        lat = 1;
        while (!i8.out_valid && lat < 40) begin
            check($sformatf("v%0d_busy_rdy", idx), 64'(i8.in_ready), 64'd0);
            step();
            lat++;
        end
        check($sformatf("v%0d_lat", idx),   64'(lat),     64'(v.lat));
        check($sformatf("v%0d_out", idx),   64'(i8.out),  64'(v.res));
        check($sformatf("v%0d_zero", idx),  64'(i8.zero), 64'(v.res == 8'h00));
        check($sformatf("v%0d_carry", idx), 64'(i8.carry), 64'(v.c));
        check($sformatf("v%0d_dz", idx),    64'(i8.dz),   64'(v.dz));
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic seen;
        vecs = '{
            '{4'd3,  8'h12, 8'h10, 8'd9, 8'h20, 1'b1, 1'b0},
            '{4'd6,  8'h64, 8'h07, 8'd9, 8'h0E, 1'b0, 1'b0},
            '{4'd11, 8'h64, 8'h07, 8'd9, 8'h02, 1'b0, 1'b0},
            '{4'd6,  8'h05, 8'h00, 8'd1, 8'hFF, 1'b0, 1'b1},
            '{4'd11, 8'h05, 8'h00, 8'd1, 8'h05, 1'b0, 1'b1},
            '{4'd5,  8'h80, 8'h07, 8'd1, 8'h01, 1'b0, 1'b0},
            '{4'd4,  8'h01, 8'h08, 8'd1, 8'h00, 1'b0, 1'b0},
            '{4'd4,  8'h81, 8'h01, 8'd1, 8'h02, 1'b0, 1'b0},
            '{4'd3,  8'hFF, 8'hFF, 8'd9, 8'h01, 1'b1, 1'b0},
            '{4'd3,  8'h03, 8'h05, 8'd9, 8'h0F, 1'b0, 1'b0},
            '{4'd6,  8'h07, 8'h64, 8'd9, 8'h00, 1'b0, 1'b0},
            '{4'd11, 8'h07, 8'h64, 8'd9, 8'h07, 1'b0, 1'b0},
            '{4'd7,  8'h0F, 8'h00, 8'd1, 8'hF0, 1'b0, 1'b0},
            '{4'd8,  8'hF0, 8'h3C, 8'd1, 8'h30, 1'b0, 1'b0},
            '{4'd9,  8'hF0, 8'h0F, 8'd1, 8'hFF, 1'b0, 1'b0},
            '{4'd12, 8'h03, 8'h04, 8'd1, 8'h07, 1'b0, 1'b0},
            '{4'd0,  8'hFF, 8'h01, 8'd1, 8'h00, 1'b1, 1'b0},
            '{4'd2,  8'h07, 8'h05, 8'd1, 8'h02, 1'b0, 1'b0},
            '{4'd6,  8'hFF, 8'h01, 8'd9, 8'hFF, 1'b0, 1'b0},
            '{4'd5,  8'h80, 8'h08, 8'd1, 8'h00, 1'b0, 1'b0}
        };
        i64.in_valid = 1'b0; i64.ctl = 4'd0; i64.a = '0; i64.b = '0; i64.out_ready = 1'b1;
        i8.in_valid  = 1'b0; i8.ctl  = 4'd0; i8.a  = '0; i8.b  = '0; i8.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  64'(i64.in_ready),  64'd1);
        check("rst_out_valid", 64'(i64.out_valid), 64'd0);
        check("rst_out",       i64.out,            64'd0);
        check("rst_zero",      64'(i64.zero),      64'd1);
        check("rst_carry",     64'(i64.carry),     64'd0);
        check("rst_dz",        64'(i64.dz),        64'd0);
        check("rst_in_ready8", 64'(i8.in_ready),   64'd1);

        // 64-bit ADD wrap with carry, single-cycle valid pulse
        go64(4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("add64_valid", 64'(i64.out_valid), 64'd1);
        check("add64_out",   i64.out,            64'd0);
        check("add64_zero",  64'(i64.zero),      64'd1);
        check("add64_carry", 64'(i64.carry),     64'd1);
        step();
        check("add64_pulse", 64'(i64.out_valid), 64'd0);

        // 64-bit shift boundary
        go64(4'd4, 64'd1, 64'd63);
        check("shl63_out",  i64.out,       64'h8000_0000_0000_0000);
        check("shl63_zero", 64'(i64.zero), 64'd0);
        step();
        go64(4'd4, 64'd1, 64'd64);
        check("shl64_out",  i64.out,       64'd0);
        check("shl64_zero", 64'(i64.zero), 64'd1);
        step();

        // Back-to-back single-cycle ops with out_ready held
        i8.ctl = 4'd2; i8.a = 8'h05; i8.b = 8'h07; i8.in_valid = 1'b1;
        check("b2b_rdy0", 64'(i8.in_ready), 64'd1);
        step();
        check("b2b_sub_out",   64'(i8.out),       64'hFE);
        check("b2b_sub_carry", 64'(i8.carry),     64'd1);
        check("b2b_sub_valid", 64'(i8.out_valid), 64'd1);
        check("b2b_rdy1",      64'(i8.in_ready),  64'd1);
        i8.ctl = 4'd10; i8.a = 8'hF0; i8.b = 8'h0F;
        step();
        check("b2b_xor_out",   64'(i8.out),       64'hFF);
        check("b2b_xor_carry", 64'(i8.carry),     64'd0);
        check("b2b_xor_valid", 64'(i8.out_valid), 64'd1);
        i8.in_valid = 1'b0;
        step();
        check("b2b_drain", 64'(i8.out_valid), 64'd0);

        for (int i = 0; i < NV; i++) run8(vecs[i], i);

        // Backpressure: result held, pending request ignored until consumed
        i8.out_ready = 1'b0;
        i8.ctl = 4'd1; i8.a = 8'h03; i8.b = 8'h04; i8.in_valid = 1'b1;
        step();
        i8.a = 8'h01; i8.b = 8'h01;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_out", k),   64'(i8.out),       64'h07);
            check($sformatf("bp%0d_valid", k), 64'(i8.out_valid), 64'd1);
            check($sformatf("bp%0d_rdy", k),   64'(i8.in_ready),  64'd0);
            step();
        end
        i8.out_ready = 1'b1;
        #1;
        check("bp_rdy_rise", 64'(i8.in_ready), 64'd1);
        step();
        check("bp_next_out",   64'(i8.out),       64'h02);
        check("bp_next_valid", 64'(i8.out_valid), 64'd1);
        i8.in_valid = 1'b0;
        step();

        // Reset in the middle of a MUL
        i8.ctl = 4'd3; i8.a = 8'h12; i8.b = 8'h10; i8.in_valid = 1'b1;
        step();
        i8.in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("mrst_valid", 64'(i8.out_valid), 64'd0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (i8.out_valid) seen = 1'b1;
            step();
        end
        check("mrst_no_valid", 64'(seen), 64'd0);
        check("mrst_rdy",      64'(i8.in_ready), 64'd1);
        run8('{4'd1, 8'h01, 8'h01, 8'd1, 8'h02, 1'b0, 1'b0}, 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
